instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Program counter, program memory and optional return stack
//               (enabled by defining RET_STACK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int OP_SIZE     = 4,
    parameter int ARG_SIZE    = 3,
    parameter int ARG_NUM     = 2,
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                done,
    input  logic                                branch,
    input  logic                                link,
    input  logic                                ret,
    input  logic [ADDR_W-1:0]                   branch_addr,
    input  logic                                load_we,
    input  logic [ADDR_W-1:0]                   load_addr,
    input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] load_data,
    output logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0] instruction,
    output logic [ADDR_W-1:0]                   pc,
    output logic                                instr_valid,
    output logic                                stack_empty,
    output logic                                stack_full,
    output logic                                fault
);

    localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [IW-1:0]     r_mem [2**ADDR_W];
    logic [IW-1:0]     r_instr;
    logic              r_valid;
    logic              r_started;

    assign w_pc_inc = r_pc + ADDR_W'(1);

`ifdef RET_STACK_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [DW-1:0]     r_depth;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == DW'(STACK_DEPTH));
    assign w_top   = r_stack[SW'(r_depth - DW'(1))];
`else
    logic w_unused;
    assign w_unused = ^{link, ret, 1'(STACK_DEPTH)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: ret > branch > done > hold; a faulting request leaves PC as is.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef RET_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        if (r_state == ST_RUN) begin
`ifdef RET_STACK_EN
            if (ret) begin
                if (w_empty) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_pc_nxt = w_top;
                    w_pop    = 1'b1;
                end
            end else if (branch) begin
                if (link && w_full) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_pc_nxt = branch_addr;
                    w_push   = link;
                end
            end else if (done) begin
                w_pc_nxt = w_pc_inc;
            end
`else
            if (branch) begin
                w_pc_nxt = branch_addr;
            end else if (done) begin
                w_pc_nxt = w_pc_inc;
            end
`endif
        end
    end

    // Instruction register reads the address PC is about to take (write-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_instr   <= (load_we && (load_addr == w_pc_nxt)) ? load_data : r_mem[w_pc_nxt];
            r_valid   <= r_started && (w_state_nxt == ST_RUN);
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

`ifdef RET_STACK_EN
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[SW'(r_depth)] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
        end else if (w_push) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_pop) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign fault       = (r_state == ST_FAULT);
`else
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign fault       = 1'b0;
`endif

    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instr_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch (vector table, directed
//               call/return sequences, randomized run against a reference).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;

    localparam int OPS = 4;
    localparam int AS  = 3;
    localparam int AN  = 2;
    localparam int AW  = 4;
    localparam int SD  = 4;
    localparam int IW  = OPS + AN * AS;
    localparam int NW  = 1 << AW;
`ifdef RET_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          done, branch, link, ret, load_we;
    logic [AW-1:0] branch_addr, load_addr;
    logic [IW-1:0] load_data;
    logic [IW-1:0] instruction;
    logic [AW-1:0] pc;
    logic          instr_valid, stack_empty, stack_full, fault;

    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch #(
        .OP_SIZE    (OPS),
        .ARG_SIZE   (AS),
        .ARG_NUM    (AN),
        .ADDR_W     (AW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .branch     (branch),
        .link       (link),
        .ret        (ret),
        .branch_addr(branch_addr),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .instruction(instruction),
        .pc         (pc),
        .instr_valid(instr_valid),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays and a queue used as the return stack.
    logic [IW-1:0] m_mem [NW];
    int            m_pc;
    logic [IW-1:0] m_instr;
    bit            m_valid, m_fault, m_started;
    int            m_stk [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_pc      = 0;
        m_instr   = '0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
        m_started = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_edge();
        int nxt;
        nxt = m_pc;
        if (!m_fault) begin
            if (STK && ret) begin
                if (m_stk.size() == 0) m_fault = 1'b1;
                else                   nxt = m_stk.pop_back();
            end else if (branch) begin
                if (STK && link) begin
                    if (m_stk.size() == SD) begin
                        m_fault = 1'b1;
                    end else begin
                        m_stk.push_back((m_pc + 1) % NW);
                        nxt = int'(branch_addr);
                    end
                end else begin
                    nxt = int'(branch_addr);
                end
            end else if (done) begin
                nxt = (m_pc + 1) % NW;
            end
        end
        if (load_we) m_mem[load_addr] = load_data;
        m_pc      = nxt;
        m_instr   = m_mem[m_pc];
        m_valid   = m_started && !m_fault;
        m_started = 1'b1;
    endtask

    task automatic chk_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instruction", 32'(instruction), 32'(m_instr));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
        chk("stack_full", 32'(stack_full), 32'(m_stk.size() == SD));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic clear_inputs();
        done = 0; branch = 0; link = 0; ret = 0; load_we = 0;
        branch_addr = '0; load_addr = '0; load_data = '0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit d, input bit b, input bit l, input bit r,
                        input logic [AW-1:0] ba, input bit we,
                        input logic [AW-1:0] wa, input logic [IW-1:0] wd);
        done = d; branch = b; link = l; ret = r; branch_addr = ba;
        load_we = we; load_addr = wa; load_data = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit keep_inputs);
        @(negedge clk);
        if (!keep_inputs) clear_inputs();
        rst = 1'b1;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_stack_empty", 32'(stack_empty), 32'd1);
        chk("rst_stack_full", 32'(stack_full), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    typedef struct {
        bit            d, b, l;
        logic [AW-1:0] ba;
        bit            we;
        logic [AW-1:0] wa;
        logic [IW-1:0] wd;
        int            epc;
        logic [IW-1:0] ein;
        bit            ev;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Program image: mem[i] = 0x300 + 5*i
        vecs[0]  = '{0, 0, 0, 4'd0,  0, 4'd0, 10'h000,  0, 10'h300, 0};
        vecs[1]  = '{1, 0, 0, 4'd0,  0, 4'd0, 10'h000,  1, 10'h305, 1};
        vecs[2]  = '{1, 0, 0, 4'd0,  0, 4'd0, 10'h000,  2, 10'h30A, 1};
        vecs[3]  = '{1, 0, 0, 4'd0,  0, 4'd0, 10'h000,  3, 10'h30F, 1};
        vecs[4]  = '{1, 0, 0, 4'd0,  1, 4'd4, 10'h2A5,  4, 10'h2A5, 1};
        vecs[5]  = '{0, 1, 0, 4'd15, 0, 4'd0, 10'h000, 15, 10'h34B, 1};
        vecs[6]  = '{1, 0, 0, 4'd0,  0, 4'd0, 10'h000,  0, 10'h300, 1};
        vecs[7]  = '{0, 0, 1, 4'd9,  0, 4'd0, 10'h000,  0, 10'h300, 1};
        vecs[8]  = '{0, 0, 0, 4'd0,  1, 4'd0, 10'h155,  0, 10'h155, 1};
        vecs[9]  = '{1, 1, 0, 4'd7,  0, 4'd0, 10'h000,  7, 10'h323, 1};
        vecs[10] = '{1, 0, 0, 4'd0,  1, 4'd9, 10'h0AA,  8, 10'h328, 1};
        vecs[11] = '{1, 0, 0, 4'd0,  0, 4'd0, 10'h000,  9, 10'h0AA, 1};

        clear_inputs();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            load_we = 1; load_addr = AW'(i); load_data = IW'(10'h300 + 5 * i);
            @(posedge clk);
            m_mem[i] = load_data;
        end
        do_reset(1'b0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].d, vecs[i].b, vecs[i].l, 1'b0, vecs[i].ba,
                 vecs[i].we, vecs[i].wa, vecs[i].wd);
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].epc));
            chk($sformatf("vec%0d_instruction", i), 32'(instruction), 32'(vecs[i].ein));
            chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
        end

`ifdef RET_STACK_EN
        // Call from pc 2 to 9, then return to 3.
        do_reset(1'b0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'd9, 0, 0, 0);
        chk("call_pc", 32'(pc), 32'd9);
        chk("call_stack_empty", 32'(stack_empty), 32'd0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("ret_pc", 32'(pc), 32'd3);
        chk("ret_stack_empty", 32'(stack_empty), 32'd1);
        chk_all();

        // Five nested calls overflow a four-entry stack.
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) step(0, 1, 1, 0, AW'(i), 0, 0, 0);
        chk("nest4_stack_full", 32'(stack_full), 32'd1);
        chk("nest4_pc", 32'(pc), 32'd4);
        step(0, 1, 1, 0, 4'd8, 0, 0, 0);
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_pc", 32'(pc), 32'd4);
        chk("ovf_instr_valid", 32'(instr_valid), 32'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("frozen_pc", 32'(pc), 32'd4);
        chk_all();
        do_reset(1'b0);

        // ret beats branch; then ret on empty stack faults.
        step(0, 1, 0, 0, 4'd4, 0, 0, 0);
        step(0, 1, 1, 0, 4'd10, 0, 0, 0);
        step(0, 1, 0, 1, 4'd12, 0, 0, 0);
        chk("retprio_pc", 32'(pc), 32'd5);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("udf_fault", 32'(fault), 32'd1);
        chk("udf_pc", 32'(pc), 32'd5);
        chk_all();

        // Reset arriving with a call in flight drops the push.
        do_reset(1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        done = 0; branch = 1; link = 1; branch_addr = 4'd6;
        do_reset(1'b1);
        chk("rstcall_stack_empty", 32'(stack_empty), 32'd1);
        chk("rstcall_pc", 32'(pc), 32'd0);
`else
        // Without the stack, link is ignored and ret never moves PC.
        do_reset(1'b0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4'd9, 0, 0, 0);
        chk("plaincall_pc", 32'(pc), 32'd9);
        chk("plaincall_stack_empty", 32'(stack_empty), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("noret_pc", 32'(pc), 32'd9);
        chk("noret_fault", 32'(fault), 32'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("retdone_pc", 32'(pc), 32'd10);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, AW'(i), 0, 0, 0);
        chk("nostk_full", 32'(stack_full), 32'd0);
        chk("nostk_valid", 32'(instr_valid), 32'd1);
        chk_all();
`endif

        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset(1'b0);
            end else begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7) == 0,
                     AW'($urandom_range(0, NW - 1)),
                     $urandom_range(0, 3) == 0,
                     AW'($urandom_range(0, NW - 1)),
                     IW'($urandom_range(0, (1 << IW) - 1)));
            end
            chk_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
